alu_ctrl_decoder: RTL and testbench

Registered decode stage that turns a 32-bit RV32IM instruction into the 5-bit ALU SELECT code and the operand and control signals for the EX stage. It is the encoder that drives the ALU's opcode interface and sits between the IF/ID register and EX. It also generates immediates and pipeline controls. It supports stall and flush and flags instructions it does not support.

---
 rtl/alu_ctrl_decoder_if.sv | 43 ++++
 rtl/alu_ctrl_decoder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alu_ctrl_decoder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_decoder_if.sv
// Handshake bundle between IF/ID and the ALU control decoder.
// master = upstream fetch/hazard side, slave = decoder.
interface alu_ctrl_decoder_if #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 5
);
  logic             in_valid;
  logic [31:0]      instr;
  logic [XLEN-1:0]  pc;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [SEL_W-1:0] alu_select;
  logic [1:0]       op1_sel;
  logic [1:0]       op2_sel;
  logic [XLEN-1:0]  imm;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [4:0]       rd_addr;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             branch;
  logic             jump;
  logic [2:0]       branch_type;
  logic             illegal;

  modport master (
    output in_valid, instr, pc, stall, flush,
    input  out_valid, alu_select, op1_sel, op2_sel, imm,
    input  rs1_addr, rs2_addr, rd_addr,
    input  reg_write, mem_read, mem_write, branch, jump,
    input  branch_type, illegal
  );

  modport slave (
    input  in_valid, instr, pc, stall, flush,
    output out_valid, alu_select, op1_sel, op2_sel, imm,
    output rs1_addr, rs2_addr, rd_addr,
    output reg_write, mem_read, mem_write, branch, jump,
    output branch_type, illegal
  );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// RV32IM decode stage: instruction -> ALU select, operands, immediates
// and pipeline controls, registered with flush > stall > load priority.
module alu_ctrl_decoder #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 5
) (
  input logic               clk,
  input logic               resetn,
  alu_ctrl_decoder_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] sel;
    logic [1:0]       op1;
    logic [1:0]       op2;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             rw;
    logic             mr;
    logic             mw;
    logic             br;
    logic             jp;
    logic [2:0]       bt;
    logic             ill;
  } ex_ctl_t;

  localparam logic [SEL_W-1:0] SEL_ADD  = 5'b00000;
  localparam logic [SEL_W-1:0] SEL_SLL  = 5'b00001;
  localparam logic [SEL_W-1:0] SEL_SLT  = 5'b00010;
  localparam logic [SEL_W-1:0] SEL_SLTU = 5'b00011;
  localparam logic [SEL_W-1:0] SEL_SRL  = 5'b00101;
  localparam logic [SEL_W-1:0] SEL_SUB  = 5'b10000;
  localparam logic [SEL_W-1:0] SEL_SRA  = 5'b10101;
  localparam logic [SEL_W-1:0] SEL_MUL  = 5'b11000;
  localparam logic [SEL_W-1:0] SEL_DIV  = 5'b11100;
  localparam logic [SEL_W-1:0] SEL_REM  = 5'b11101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;
  localparam logic [1:0] OP2_RS2  = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_FOUR = 2'd2;

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign instr = bus.instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  logic is_op;
  logic is_opimm;
  logic is_load;
  logic is_store;
  logic is_lui;
  logic is_auipc;
  logic is_jal;
  logic is_jalr;
  logic is_branch;

  assign is_op     = (opc == OPC_OP);
  assign is_opimm  = (opc == OPC_OPIMM);
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);
  assign is_lui    = (opc == OPC_LUI);
  assign is_auipc  = (opc == OPC_AUIPC);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_branch = (opc == OPC_BRANCH);

  ex_ctl_t d;
  ex_ctl_t q;
  logic    bad;

  always_comb begin
    d       = '0;
    bad     = 1'b0;
    d.valid = bus.in_valid;
    d.rs1   = instr[19:15];
    d.rs2   = instr[24:20];
    d.rd    = instr[11:7];
    unique case (1'b1)
      is_op: begin
        d.rw = 1'b1;
        unique case (f7)
          F7_BASE: d.sel = {2'b00, f3};
          F7_ALT: begin
            if (f3 == 3'b000)      d.sel = SEL_SUB;
            else if (f3 == 3'b101) d.sel = SEL_SRA;
            else                   bad   = 1'b1;
          end
          F7_MULDIV: begin
            unique case (f3)
              3'b000:  d.sel = SEL_MUL;
              3'b100:  d.sel = SEL_DIV;
              3'b110:  d.sel = SEL_REM;
              default: bad   = 1'b1;
            endcase
          end
          default: bad = 1'b1;
        endcase
      end
      is_opimm: begin
        d.rw  = 1'b1;
        d.op2 = OP2_IMM;
        d.imm = sx(imm_i);
        // shifts carry shamt in the low imm bits, funct7 picks the kind
        if (f3 == 3'b001) begin
          d.imm = XLEN'(instr[24:20]);
          if (f7 == F7_BASE) d.sel = SEL_SLL;
          else               bad   = 1'b1;
        end else if (f3 == 3'b101) begin
          d.imm = XLEN'(instr[24:20]);
          if (f7 == F7_BASE)     d.sel = SEL_SRL;
          else if (f7 == F7_ALT) d.sel = SEL_SRA;
          else                   bad   = 1'b1;
        end else begin
          d.sel = {2'b00, f3};
        end
      end
      is_load: begin
        d.sel = SEL_ADD;
        d.op2 = OP2_IMM;
        d.imm = sx(imm_i);
        d.mr  = 1'b1;
        d.rw  = 1'b1;
      end
      is_store: begin
        d.sel = SEL_ADD;
        d.op2 = OP2_IMM;
        d.imm = sx(imm_s);
        d.mw  = 1'b1;
        d.rd  = '0;
      end
      is_lui: begin
        d.op1 = OP1_ZERO;
        d.op2 = OP2_IMM;
        d.imm = sx(imm_u);
        d.rw  = 1'b1;
      end
      is_auipc: begin
        d.op1 = OP1_PC;
        d.op2 = OP2_IMM;
        d.imm = sx(imm_u);
        d.rw  = 1'b1;
      end
      is_jal: begin
        d.op1 = OP1_PC;
        d.op2 = OP2_FOUR;
        d.imm = sx(imm_j);
        d.jp  = 1'b1;
        d.rw  = 1'b1;
      end
      is_jalr: begin
        d.op1 = OP1_PC;
        d.op2 = OP2_FOUR;
        d.imm = sx(imm_i);
        d.jp  = 1'b1;
        d.rw  = 1'b1;
        bad   = (f3 != 3'b000);
      end
      is_branch: begin
        d.op1 = OP1_RS1;
        d.op2 = OP2_RS2;
        d.imm = sx(imm_b);
        d.br  = 1'b1;
        d.bt  = f3;
        d.rd  = '0;
        unique case (f3)
          3'b000, 3'b001: d.sel = SEL_SUB;
          3'b100, 3'b101: d.sel = SEL_SLT;
          3'b110, 3'b111: d.sel = SEL_SLTU;
          default:        bad   = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // an illegal op still travels as valid so the trap logic can see it
    if (bad) begin
      d.sel = '0;
      d.rw  = 1'b0;
      d.mr  = 1'b0;
      d.mw  = 1'b0;
      d.br  = 1'b0;
      d.jp  = 1'b0;
      d.bt  = '0;
    end
    d.ill = bad;
    if (!bus.in_valid) begin
      d.rw  = 1'b0;
      d.mr  = 1'b0;
      d.mw  = 1'b0;
      d.br  = 1'b0;
      d.jp  = 1'b0;
      d.ill = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (bus.flush) begin
      q <= '0;
    end else if (!bus.stall) begin
      q <= d;
    end
  end

  assign bus.out_valid   = q.valid;
  assign bus.alu_select  = q.sel;
  assign bus.op1_sel     = q.op1;
  assign bus.op2_sel     = q.op2;
  assign bus.imm         = q.imm;
  assign bus.rs1_addr    = q.rs1;
  assign bus.rs2_addr    = q.rs2;
  assign bus.rd_addr     = q.rd;
  assign bus.reg_write   = q.rw;
  assign bus.mem_read    = q.mr;
  assign bus.mem_write   = q.mw;
  assign bus.branch      = q.br;
  assign bus.jump        = q.jp;
  assign bus.branch_type = q.bt;
  assign bus.illegal     = q.ill;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Scoreboard bench for alu_ctrl_decoder: directed plan cases plus
// randomized instructions/stall/flush against a mnemonic-level model.
module tb_alu_ctrl_decoder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_decoder_if bus ();

  alu_ctrl_decoder dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // mode 0: check every field, 1: illegal (trap-visible fields),
  // 2: bubble (valid and control bits only)
  typedef struct {
    logic        valid;
    logic [4:0]  sel;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  ctl;
    logic [2:0]  bt;
    logic        ill;
    int          mode;
  } exp_t;

  localparam logic [4:0] ADD = 5'b00000, SLL = 5'b00001, SLT = 5'b00010;
  localparam logic [4:0] SLTU = 5'b00011, XOR = 5'b00100, SRL = 5'b00101;
  localparam logic [4:0] OR = 5'b00110, AND = 5'b00111, SUB = 5'b10000;
  localparam logic [4:0] SRA = 5'b10101, MUL = 5'b11000, DIV = 5'b11100;
  localparam logic [4:0] REM = 5'b11101;
  // ctl = {reg_write, mem_read, mem_write, branch, jump}
  localparam logic [4:0] C_RW = 5'b10000, C_MR = 5'b01000;
  localparam logic [4:0] C_MW = 5'b00100, C_BR = 5'b00010;
  localparam logic [4:0] C_JP = 5'b00001;

  exp_t q[$];
  exp_t cur;
  int checks = 0;
  int failures = 0;

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [4:0] base [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] ii, is, ib, ij, iu;
    logic bad;
    base = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    opc = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    ii = 32'($signed(w) >>> 20);
    is = (ii & 32'hFFFF_FFE0) | 32'(w[11:7]);
    ib = (32'($signed(w) >>> 19) & 32'hFFFF_F000) | (32'(w[7]) << 11)
       | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    ij = (32'($signed(w) >>> 11) & 32'hFFF0_0000) | (w & 32'h000F_F000)
       | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    iu = w & 32'hFFFF_F000;
    e = zero_exp();
    e.valid = 1'b1;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd = w[11:7];
    bad = 1'b0;
    case (opc)
      7'h33: begin
        e.ctl = C_RW;
        if (f7 == 7'h00) e.sel = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.sel = SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.sel = SRA;
        else if (f7 == 7'h01 && f3 == 3'd0) e.sel = MUL;
        else if (f7 == 7'h01 && f3 == 3'd4) e.sel = DIV;
        else if (f7 == 7'h01 && f3 == 3'd6) e.sel = REM;
        else bad = 1'b1;
      end
      7'h13: begin
        e.ctl = C_RW;
        e.op2 = 2'd1;
        e.imm = ii;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm = 32'(w[24:20]);
          if (f3 == 3'd1 && f7 == 7'h00) e.sel = SLL;
          else if (f3 == 3'd5 && f7 == 7'h00) e.sel = SRL;
          else if (f3 == 3'd5 && f7 == 7'h20) e.sel = SRA;
          else bad = 1'b1;
        end else begin
          e.sel = base[f3];
        end
      end
      7'h03: begin
        e.op2 = 2'd1; e.imm = ii; e.ctl = C_RW | C_MR;
      end
      7'h23: begin
        e.op2 = 2'd1; e.imm = is; e.ctl = C_MW; e.rd = 0;
      end
      7'h37: begin
        e.op1 = 2'd2; e.op2 = 2'd1; e.imm = iu; e.ctl = C_RW;
      end
      7'h17: begin
        e.op1 = 2'd1; e.op2 = 2'd1; e.imm = iu; e.ctl = C_RW;
      end
      7'h6F: begin
        e.op1 = 2'd1; e.op2 = 2'd2; e.imm = ij; e.ctl = C_RW | C_JP;
      end
      7'h67: begin
        e.op1 = 2'd1; e.op2 = 2'd2; e.imm = ii; e.ctl = C_RW | C_JP;
        bad = (f3 != 3'd0);
      end
      7'h63: begin
        e.imm = ib; e.ctl = C_BR; e.bt = f3; e.rd = 0;
        if (f3 == 3'd0 || f3 == 3'd1) e.sel = SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) e.sel = SLT;
        else if (f3 == 3'd6 || f3 == 3'd7) e.sel = SLTU;
        else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      e.sel = 0; e.ctl = 0; e.ill = 1'b1; e.mode = 1;
    end
    return e;
  endfunction

  function automatic void compare(input exp_t e, input string name);
    logic [4:0] ctl;
    logic ok;
    ctl = {bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump};
    ok = (bus.out_valid === e.valid) && (bus.illegal === e.ill)
      && (ctl === e.ctl);
    if (e.mode != 2)
      ok = ok && (bus.alu_select === e.sel)
        && (bus.rs1_addr === e.rs1) && (bus.rs2_addr === e.rs2);
    if (e.mode == 0)
      ok = ok && (bus.op1_sel === e.op1) && (bus.op2_sel === e.op2)
        && (bus.imm === e.imm) && (bus.rd_addr === e.rd)
        && (bus.branch_type === e.bt);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got v=%0b ill=%0b sel=%05b op=%0d/%0d imm=%08h rs=%0d/%0d rd=%0d ctl=%05b bt=%0d; want v=%0b ill=%0b sel=%05b op=%0d/%0d imm=%08h rs=%0d/%0d rd=%0d ctl=%05b bt=%0d mode=%0d",
        name, bus.out_valid, bus.illegal, bus.alu_select, bus.op1_sel,
        bus.op2_sel, bus.imm, bus.rs1_addr, bus.rs2_addr, bus.rd_addr,
        ctl, bus.branch_type, e.valid, e.ill, e.sel, e.op1, e.op2, e.imm,
        e.rs1, e.rs2, e.rd, e.ctl, e.bt, e.mode);
    end
  endfunction

  // monitor: one registered result per clock while out of reset
  always @(negedge clk) begin
    exp_t e;
    if (resetn && q.size() > 0) begin
      e = q.pop_front();
      compare(e, "decode");
    end
  end

  task automatic step(input logic v, input logic [31:0] w,
                      input logic st, input logic fl);
    @(negedge clk);
    #1;
    bus.in_valid = v;
    bus.instr = w;
    bus.pc = $urandom;
    bus.stall = st;
    bus.flush = fl;
    @(posedge clk);
    if (fl) begin
      cur = zero_exp();
    end else if (!st) begin
      if (v) begin
        cur = model(w);
      end else begin
        cur = zero_exp();
        cur.mode = 2;
      end
    end
    q.push_back(cur);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [9];
    logic [6:0] f7s [3];
    logic [31:0] w;
    int k;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};
    f7s = '{7'h00, 7'h20, 7'h01};
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) w[6:0] = opcs[k];
    k = $urandom_range(0, 3);
    if (k < 3) w[31:25] = f7s[k];
    return w;
  endfunction

  initial begin
    bus.in_valid = 1'b1;
    bus.instr = 32'h002081B3;
    bus.pc = 32'h0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    cur = zero_exp();
    repeat (2) @(negedge clk);
    compare(zero_exp(), "reset_hold");
    #1 resetn = 1'b1;

    step(1, 32'h002081B3, 0, 0);
    step(1, 32'h407302B3, 0, 0);
    step(1, 32'h40315093, 0, 0);
    step(1, 32'h02208233, 0, 0);
    step(1, 32'hFFC12083, 0, 0);
    step(1, 32'h023150B3, 0, 0);
    step(1, 32'h002081B3, 0, 0);
    step(1, 32'h40315093, 1, 0);
    step(1, 32'hFFC12083, 1, 0);
    step(1, 32'h02208233, 1, 0);
    step(1, 32'h407302B3, 1, 1);
    step(1, 32'h00208463, 0, 0);
    step(1, 32'h0020E463, 0, 0);
    step(0, 32'h002081B3, 0, 0);
    step(1, 32'hFE112E23, 0, 0);
    step(1, 32'h123450B7, 0, 0);
    step(1, 32'hFFFFF117, 0, 0);
    step(1, 32'h8000006F, 0, 0);
    step(1, 32'hFFC100E7, 0, 0);
    step(1, 32'h0001A0E7, 0, 0);
    step(1, 32'h0000A0B3, 0, 0);
    drain();

    // asynchronous reset asserted while the clock is high
    step(1, 32'h002081B3, 0, 0);
    drain();
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 compare(zero_exp(), "reset_async");
    @(posedge clk);
    #1 compare(zero_exp(), "reset_edge");
    @(negedge clk);
    #1 resetn = 1'b1;
    cur = zero_exp();

    for (int i = 0; i < 400; i++) begin
      int r;
      logic st, fl, v;
      r = $urandom_range(0, 99);
      fl = (r < 8);
      st = (r >= 5 && r < 25);
      v = ($urandom_range(0, 9) != 0);
      step(v, rand_instr(), st, fl);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
